// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if
//
// Request and response handshake bundle between the EX/MEM stage and the
// load/store unit.
//
//   request  : req_valid / req_ready, req_we, req_funct3, req_addr, req_wdata
//   response : resp_valid / resp_ready, resp_rdata, resp_err, resp_cause
//
// Modports:
//   master - the requester (pipeline stage or testbench)
//   slave  - the load/store unit
// ---------------------------------------------------------------------------
interface lsu_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [1:0]  resp_cause;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err, resp_cause
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err, resp_cause
   );

endinterface

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu
//
// Load/store unit in front of the 64-byte data memory. Takes one request at
// a time, decodes the RISC-V load/store funct3, checks funct3 legality,
// alignment and address range, performs a single-cycle memory access for
// legal requests and returns either extended load data or a fault cause.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   bus        - lsu_if.slave: request and response handshakes
//   dm_wr      - data-memory write enable (only in ACCESS for a store)
//   dm_addr    - data-memory byte address (latched request address)
//   dm_din     - data-memory write data (latched store data)
//   dm_type    - data-memory access size: 000 word, 001 half, 011 byte
//   dm_dout    - combinational data-memory read data (zero-extended)
//   cnt_load   - completed loads
//   cnt_store  - completed stores
//   cnt_err    - faulted requests
// ---------------------------------------------------------------------------
module lsu #(
   parameter int DM_AW = 6,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   lsu_if.slave             bus,
   output logic             dm_wr,
   output logic [DM_AW-1:0] dm_addr,
   output logic [31:0]      dm_din,
   output logic [2:0]       dm_type,
   input  logic [31:0]      dm_dout,
   output logic [CNT_W-1:0] cnt_load,
   output logic [CNT_W-1:0] cnt_store,
   output logic [CNT_W-1:0] cnt_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE   = 2'b00,
      CAUSE_FUNCT3 = 2'b01,
      CAUSE_ALIGN  = 2'b10,
      CAUSE_RANGE  = 2'b11
   } cause_t;

   localparam logic [2:0] DM_WORD = 3'b000;
   localparam logic [2:0] DM_HALF = 3'b001;
   localparam logic [2:0] DM_BYTE = 3'b011;

   state_t      state;
   state_t      state_nxt;

   // Latched request fields not already visible on the dm_* outputs.
   logic        lat_we;
   logic [2:0]  lat_f3;

   // Response registers.
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   cause_t      rsp_cause;

   logic        accept;
   logic        f3_legal;
   cause_t      chk_cause;
   logic [31:0] ld_ext;

   // Size encoding for the memory port, taken from funct3[1:0].
   function automatic logic [2:0] size_to_dm_type(input logic [1:0] sz);
      case (sz)
         2'b00:   return DM_BYTE;
         2'b01:   return DM_HALF;
         default: return DM_WORD;
      endcase
   endfunction

   // ------------------------------------------------------------------------
   // Fault classification of the request currently on the bus.
   // Priority: illegal funct3, then misalignment, then range.
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned in an always_comb gets a default first,
      // so no path through the block leaves it unassigned and infers a latch.
      f3_legal  = 1'b0;
      chk_cause = CAUSE_NONE;

      if (bus.req_we)
         f3_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
      else
         f3_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

      if (!f3_legal)
         chk_cause = CAUSE_FUNCT3;
      else if ((bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) ||
               (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]))
         chk_cause = CAUSE_ALIGN;
      else if (bus.req_addr[31:DM_AW] != '0)
         chk_cause = CAUSE_RANGE;
   end

   // ------------------------------------------------------------------------
   // Load data extension, selected by the latched funct3.
   // ------------------------------------------------------------------------
   always_comb begin
      ld_ext = dm_dout;
      case (lat_f3)
         3'b000:  ld_ext = {{24{dm_dout[7]}},  dm_dout[7:0]};
         3'b001:  ld_ext = {{16{dm_dout[15]}}, dm_dout[15:0]};
         3'b100:  ld_ext = {24'h0, dm_dout[7:0]};
         3'b101:  ld_ext = {16'h0, dm_dout[15:0]};
         default: ld_ext = dm_dout;
      endcase
   end

   assign accept = (state == IDLE) && bus.req_valid;

   // ------------------------------------------------------------------------
   // FSM state register.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // ------------------------------------------------------------------------
   // FSM next state and state-decoded outputs. dm_wr comes straight from the
   // state register, so asserting rst forces it low without waiting for an
   // edge and an interrupted store never commits.
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt      = state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      dm_wr          = 1'b0;

      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid)
               state_nxt = (chk_cause == CAUSE_NONE) ? ACCESS : RESP;
         end
         ACCESS: begin
            dm_wr     = lat_we;
            state_nxt = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Request latch, response registers and statistics counters.
   // The response registers are cleared on every acceptance so a faulted or
   // store response always reports zero data.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_we    <= 1'b0;
         lat_f3    <= 3'b000;
         dm_addr   <= '0;
         dm_din    <= '0;
         dm_type   <= DM_WORD;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         rsp_cause <= CAUSE_NONE;
         cnt_load  <= '0;
         cnt_store <= '0;
         cnt_err   <= '0;
      end else begin
         if (accept) begin
            lat_we    <= bus.req_we;
            lat_f3    <= bus.req_funct3;
            dm_addr   <= bus.req_addr[DM_AW-1:0];
            dm_din    <= bus.req_wdata;
            dm_type   <= size_to_dm_type(bus.req_funct3[1:0]);
            rsp_rdata <= '0;
            rsp_err   <= (chk_cause != CAUSE_NONE);
            rsp_cause <= chk_cause;
            if (chk_cause != CAUSE_NONE)
               cnt_err <= cnt_err + CNT_W'(1);
         end

         if (state == ACCESS) begin
            if (lat_we) begin
               cnt_store <= cnt_store + CNT_W'(1);
            end else begin
               rsp_rdata <= ld_ext;
               cnt_load  <= cnt_load + CNT_W'(1);
            end
         end
      end
   end

   assign bus.resp_rdata = rsp_rdata;
   assign bus.resp_err   = rsp_err;
   assign bus.resp_cause = rsp_cause;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu
//
// Bench for lsu. Contains a byte-array data memory for the DUT to access, a
// reference model that predicts each response from the load/store rules on a
// separate byte array, a scoreboard queue filled when a request is accepted,
// and a monitor that compares every presented response against the queue
// head on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_lsu;

   logic        clk;
   logic        rst;
   logic        dm_wr;
   logic [5:0]  dm_addr;
   logic [31:0] dm_din;
   logic [2:0]  dm_type;
   logic [31:0] dm_dout;
   logic [15:0] cnt_load;
   logic [15:0] cnt_store;
   logic [15:0] cnt_err;

   lsu_if bus ();

   lsu #(.DM_AW(6), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dm_wr     (dm_wr),
      .dm_addr   (dm_addr),
      .dm_din    (dm_din),
      .dm_type   (dm_type),
      .dm_dout   (dm_dout),
      .cnt_load  (cnt_load),
      .cnt_store (cnt_store),
      .cnt_err   (cnt_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------- counts
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------- data memory
   function automatic logic [7:0] init_byte(input int i);
      return 8'(i * 37 + 11);
   endfunction

   logic [7:0] mem [64];
   logic [5:0] a1, a2, a3;
   assign a1 = dm_addr + 6'd1;
   assign a2 = dm_addr + 6'd2;
   assign a3 = dm_addr + 6'd3;

   assign dm_dout = (dm_type == 3'b011) ? {24'h0, mem[dm_addr]} :
                    (dm_type == 3'b001) ? {16'h0, mem[a1], mem[dm_addr]} :
                                          {mem[a3], mem[a2], mem[a1], mem[dm_addr]};

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = init_byte(i);
      forever begin
         @(posedge clk);
         if (dm_wr) begin
            case (dm_type)
               3'b011: mem[dm_addr] <= dm_din[7:0];
               3'b001: begin
                  mem[dm_addr] <= dm_din[7:0];
                  mem[a1]      <= dm_din[15:8];
               end
               default: begin
                  mem[dm_addr] <= dm_din[7:0];
                  mem[a1]      <= dm_din[15:8];
                  mem[a2]      <= dm_din[23:16];
                  mem[a3]      <= dm_din[31:24];
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------- reference model
   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [1:0]  cause;
   } exp_t;

   logic [7:0] ref_mem [64];
   int m_ld  = 0;
   int m_st  = 0;
   int m_err = 0;
   int st_total = 0;
   exp_t exp_q [$];

   function automatic exp_t model(input bit we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd);
      exp_t        e;
      int          size;
      int          base;
      logic [31:0] v;
      e    = '0;
      v    = '0;
      size = 1 << f3[1:0];
      base = int'(addr[5:0]);
      if (we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
         e.err = 1'b1; e.cause = 2'd1;
      end else if ((addr % 32'(size)) != 32'd0) begin
         e.err = 1'b1; e.cause = 2'd2;
      end else if (addr > 32'd63) begin
         e.err = 1'b1; e.cause = 2'd3;
      end
      if (e.err) begin
         m_err++;
      end else if (we) begin
         for (int i = 0; i < size; i++) ref_mem[base + i] = wd[8*i +: 8];
         m_st++;
         st_total++;
      end else begin
         for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[base + i];
         if (!f3[2] && size < 4 && v[8*size-1])
            for (int b = 8*size; b < 32; b++) v[b] = 1'b1;
         e.rdata = v;
         m_ld++;
      end
      return e;
   endfunction

   // -------------------------------------------- response ready driver
   bit rand_ready  = 1'b0;
   bit ready_level = 1'b1;

   always @(posedge clk) begin
      #2;
      bus.resp_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
   end

   // ---------------------------------------------------------- monitor
   int wr_cycles = 0;

   always @(negedge clk) begin
      if (dm_wr) wr_cycles++;
      if (!rst && bus.resp_valid) begin
         if (exp_q.size() == 0) begin
            check("resp_unexpected", 32'd1, 32'd0);
         end else begin
            check("resp_rdata", bus.resp_rdata, exp_q[0].rdata);
            check("resp_err", 32'(bus.resp_err), 32'(exp_q[0].err));
            check("resp_cause", 32'(bus.resp_cause), 32'(exp_q[0].cause));
            if (bus.resp_ready) void'(exp_q.pop_front());
         end
      end
   end

   // ------------------------------------------------------ stimulus tasks
   // Presents a request and waits for acceptance; returns at accept edge + 1.
   task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit track, output time t_acc);
      bit   got;
      exp_t e;
      got   = 1'b0;
      t_acc = 0;
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            @(posedge clk);
            t_acc = $time;
            got   = 1'b1;
         end
      end
      if (got) begin
         if (track) begin
            e = model(we, f3, addr, wd);
            exp_q.push_back(e);
         end
      end else begin
         check("accept_timeout", 32'd0, 32'd1);
      end
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !bus.resp_valid) done = 1'b1;
      end
      if (!done) check("drain_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic load_expect(input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] expv, input string name);
      time t;
      issue(1'b0, f3, addr, 32'h0, 1'b1, t);
      @(negedge clk);
      @(negedge clk);
      check(name, bus.resp_rdata, expv);
   endtask

   task automatic fault_expect(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [1:0] cause, input string name);
      time t;
      issue(we, f3, addr, 32'hA5A5_5A5A, 1'b1, t);
      @(negedge clk);
      check({name, "_valid"}, 32'(bus.resp_valid), 32'd1);
      check({name, "_cause"}, 32'(bus.resp_cause), 32'(cause));
      check({name, "_rdata"}, bus.resp_rdata, 32'h0);
      check({name, "_dm_wr"}, 32'(dm_wr), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_req_ready"},  32'(bus.req_ready),  32'd1);
      check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
      check({tag, "_resp_rdata"}, bus.resp_rdata,      32'd0);
      check({tag, "_resp_err"},   32'(bus.resp_err),   32'd0);
      check({tag, "_resp_cause"}, 32'(bus.resp_cause), 32'd0);
      check({tag, "_dm_wr"},      32'(dm_wr),          32'd0);
      check({tag, "_dm_addr"},    32'(dm_addr),        32'd0);
      check({tag, "_dm_din"},     dm_din,              32'd0);
      check({tag, "_dm_type"},    32'(dm_type),        32'd0);
      check({tag, "_cnt_load"},   32'(cnt_load),       32'd0);
      check({tag, "_cnt_store"},  32'(cnt_store),      32'd0);
      check({tag, "_cnt_err"},    32'(cnt_err),        32'd0);
   endtask

   task automatic check_counters(input string tag);
      check({tag, "_cnt_load"},  32'(cnt_load),  32'(m_ld));
      check({tag, "_cnt_store"}, 32'(cnt_store), 32'(m_st));
      check({tag, "_cnt_err"},   32'(cnt_err),   32'(m_err));
   endtask

   // ------------------------------------------------------------- main
   initial begin
      time t0, t1, tp;
      bit          we;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] d;
      int          r;

      for (int i = 0; i < 64; i++) ref_mem[i] = init_byte(i);
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;

      @(negedge clk);
      check_reset_vals("por");
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // Store word then load it back; check ACCESS/RESP timing of the store.
      issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, t0);
      @(negedge clk);
      check("sw_access_dm_wr",   32'(dm_wr),          32'd1);
      check("sw_access_valid",   32'(bus.resp_valid), 32'd0);
      check("sw_access_dm_addr", 32'(dm_addr),        32'h10);
      check("sw_access_dm_din",  dm_din,              32'hDEADBEEF);
      check("sw_access_dm_type", 32'(dm_type),        32'd0);
      @(negedge clk);
      check("sw_resp_valid", 32'(bus.resp_valid), 32'd1);
      check("sw_resp_dm_wr", 32'(dm_wr),          32'd0);
      load_expect(3'b010, 32'h10, 32'hDEADBEEF, "lw_0x10");
      drain();
      check("sw_lw_cnt_store", 32'(cnt_store), 32'd1);
      check("sw_lw_cnt_load",  32'(cnt_load),  32'd1);

      // Byte and half sign/zero extension.
      issue(1'b1, 3'b000, 32'h21, 32'h0000_0080, 1'b1, t0);
      load_expect(3'b000, 32'h21, 32'hFFFF_FF80, "lb_0x21");
      load_expect(3'b100, 32'h21, 32'h0000_0080, "lbu_0x21");
      issue(1'b1, 3'b001, 32'h22, 32'h0000_8001, 1'b1, t0);
      load_expect(3'b001, 32'h22, 32'hFFFF_8001, "lh_0x22");
      load_expect(3'b101, 32'h22, 32'h0000_8001, "lhu_0x22");
      drain();
      check_counters("ext");

      // Fault classification and priority.
      fault_expect(1'b0, 3'b010, 32'h12, 2'b10, "lw_misalign");
      fault_expect(1'b1, 3'b001, 32'h07, 2'b10, "sh_misalign");
      fault_expect(1'b0, 3'b010, 32'h40, 2'b11, "lw_range");
      fault_expect(1'b1, 3'b100, 32'h08, 2'b01, "st_f3_100");
      fault_expect(1'b0, 3'b011, 32'h41, 2'b01, "f3_011_prio");
      drain();
      check("fault_cnt_err", 32'(cnt_err), 32'd5);
      check_counters("fault");

      // Backpressure: response held, second request waits for handshake.
      ready_level = 1'b0;
      @(posedge clk);
      #3;
      issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, t0);
      @(negedge clk);
      bus.req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
         check("bp_resp_rdata", bus.resp_rdata,      32'hDEADBEEF);
         check("bp_req_ready",  32'(bus.req_ready),  32'd0);
      end
      ready_level = 1'b1;
      issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, t1);
      check("bp_accept_delay", 32'(t1 - t0), 32'd80);
      drain();

      // Reset during the ACCESS cycle of a store.
      issue(1'b1, 3'b010, 32'h00, 32'h1234_5678, 1'b0, t0);
      check("mid_dm_wr_before", 32'(dm_wr), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("mid_dm_wr_async",      32'(dm_wr),          32'd0);
      check("mid_resp_valid_async", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      check_reset_vals("midrst");
      @(posedge clk);
      @(negedge clk);
      check_reset_vals("midrst_hold");
      @(posedge clk);
      #1 rst = 1'b0;
      m_ld = 0; m_st = 0; m_err = 0;
      load_expect(3'b010, 32'h00,
                  {init_byte(3), init_byte(2), init_byte(1), init_byte(0)}, "lw_after_rst");
      drain();
      check_counters("post_rst");

      // Back-to-back alternating store/load, one request per 3 cycles.
      tp = 0;
      for (int i = 0; i < 10; i++) begin
         d = $urandom;
         issue(1'b1, 3'b010, 32'(4 * i), d, 1'b1, t0);
         if (i > 0) check("b2b_period_sw", 32'(t0 - tp), 32'd30);
         issue(1'b0, 3'b010, 32'(4 * i), 32'h0, 1'b1, t1);
         check("b2b_period_lw", 32'(t1 - t0), 32'd30);
         tp = t1;
      end
      drain();
      check_counters("b2b");

      // Randomized requests with random response backpressure.
      rand_ready = 1'b1;
      for (int n = 0; n < 300; n++) begin
         we = 1'($urandom_range(0, 1));
         r  = $urandom_range(0, 99);
         if (r < 80) begin
            if (we) begin
               f3 = 3'($urandom_range(0, 2));
            end else begin
               f3 = 3'($urandom_range(0, 4));
               if (f3 > 3'd2) f3 = f3 + 3'd1;
            end
         end else begin
            f3 = 3'($urandom_range(0, 7));
         end
         r = $urandom_range(0, 99);
         a = 32'($urandom_range(0, 63));
         if (r < 70)
            a = a & ~((32'd1 << f3[1:0]) - 32'd1);
         else if (r >= 90)
            a = $urandom;
         issue(we, f3, a, $urandom, 1'b1, t0);
      end
      rand_ready = 1'b0;
      drain();
      check_counters("rand");
      check("dm_wr_cycles", 32'(wr_cycles), 32'(st_total));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
